// File: rtl/matmul_apb_master.sv
// APB initiator for the matrix-multiplier register port: single READ/WRITE
// commands plus a RUN macro that starts the engine and polls STATUS.busy.
module matmul_apb_master #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                POLL_MAX    = 1024,
  parameter logic [ADDR_W-1:0] CTRL_ADDR   = 'h00,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 'h0C
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cmd_op_q;
  logic              is_poll_q;
  logic [CNT_W-1:0]  poll_cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              init_q;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              timeout_q;

  logic              cmd_acc;
  logic              xfer_done;
  logic              ctrl_ok;
  logic              poll_busy;
  logic              poll_again;

  // init_q keeps cmd_ready_o low until the first edge after reset release
  assign cmd_acc    = (state_q == IDLE) && init_q && cmd_valid_i;
  assign xfer_done  = (state_q == ACCESS) && pready_i;
  assign cnt_inc    = poll_cnt_q + CNT_W'(1);
  assign ctrl_ok    = xfer_done && (cmd_op_q == OP_RUN) && !is_poll_q && !pslverr_i;
  assign poll_busy  = xfer_done && is_poll_q && !pslverr_i && prdata_i[0];
  assign poll_again = poll_busy && (cnt_inc != CNT_W'(POLL_MAX));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      init_q     <= 1'b0;
      cmd_op_q   <= OP_READ;
      is_poll_q  <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (cmd_acc) begin
        cmd_op_q   <= cmd_op_i;
        is_poll_q  <= 1'b0;
        poll_cnt_q <= '0;
      end else if (ctrl_ok) begin
        is_poll_q  <= 1'b1;
        poll_cnt_q <= '0;
      end else if (poll_busy) begin
        poll_cnt_q <= cnt_inc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_acc) state_d = (cmd_op_i == OP_RSVD) ? RESP : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i) state_d = (ctrl_ok || poll_again) ? SETUP : RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer and response payload; only observed through state-gated outputs
  always_ff @(posedge clk_i) begin
    if (cmd_acc) begin
      rdata_q   <= '0;
      err_q     <= (cmd_op_i == OP_RSVD);
      timeout_q <= 1'b0;
      case (cmd_op_i)
        OP_READ: begin
          addr_q   <= cmd_addr_i;
          pwrite_q <= 1'b0;
          wdata_q  <= '0;
        end
        OP_WRITE: begin
          addr_q   <= cmd_addr_i;
          pwrite_q <= 1'b1;
          wdata_q  <= cmd_wdata_i;
        end
        default: begin
          addr_q   <= CTRL_ADDR;
          pwrite_q <= 1'b1;
          wdata_q  <= cmd_wdata_i | DATA_W'(1);
        end
      endcase
    end else if (ctrl_ok) begin
      addr_q   <= STATUS_ADDR;
      pwrite_q <= 1'b0;
      wdata_q  <= '0;
    end else if (xfer_done) begin
      err_q     <= pslverr_i;
      rdata_q   <= ((cmd_op_q == OP_WRITE) || ((cmd_op_q == OP_RUN) && !is_poll_q)) ? '0 : prdata_i;
      timeout_q <= poll_busy && !poll_again;
    end
  end

  always_comb begin
    cmd_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    rsp_rdata_o   = '0;
    rsp_err_o     = 1'b0;
    rsp_timeout_o = 1'b0;
    psel_o        = 1'b0;
    penable_o     = 1'b0;
    pwrite_o      = 1'b0;
    paddr_o       = '0;
    pwdata_o      = '0;
    case (state_q)
      IDLE: cmd_ready_o = init_q;
      SETUP, ACCESS: begin
        psel_o    = 1'b1;
        penable_o = (state_q == ACCESS);
        pwrite_o  = pwrite_q;
        paddr_o   = addr_q;
        pwdata_o  = wdata_q;
      end
      RESP: begin
        rsp_valid_o   = 1'b1;
        rsp_rdata_o   = rdata_q;
        rsp_err_o     = err_q;
        rsp_timeout_o = timeout_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_apb_master.sv
// Bench for matmul_apb_master: bench-side APB slave with wait states, busy
// countdown and error injection, plus a transaction-level expectation model.
module tb_matmul_apb_master;

  localparam int          POLL_MAX    = 4;
  localparam logic [31:0] CTRL_ADDR   = 32'h00;
  localparam logic [31:0] STATUS_ADDR = 32'h0C;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int checks = 0;
  int errors = 0;

  // slave configuration, written only by the stimulus process
  int          waits = 0;
  int          busy_cfg = 0;
  int          poll_base = 0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] rd_value = '0;

  // slave/monitor state, written only by the slave process
  int          wcnt = 0;
  int          status_reads = 0;
  int          stab_bad = 0;
  int          psel_cycles = 0;
  logic [31:0] last_status = '0;
  logic [31:0] su_addr = '0, su_wd = '0;
  logic        su_wr = 1'b0;
  xfer_t       act_q[$];

  matmul_apb_master #(
    .ADDR_W(32), .DATA_W(32), .POLL_MAX(POLL_MAX),
    .CTRL_ADDR(CTRL_ADDR), .STATUS_ADDR(STATUS_ADDR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [31:0] d);
    xfer_t x;
    x.addr  = a;
    x.wr    = w;
    x.wdata = d;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // APB slave and bus monitor; random junk on pready/pslverr/prdata outside ACCESS
  always @(negedge clk) begin
    logic [31:0] r;
    r = $urandom;
    if (psel) psel_cycles++;
    if (psel && !pwrite && pwdata != 32'h0) stab_bad++;
    if (psel && penable) begin
      if (paddr != su_addr || pwrite != su_wr || pwdata != su_wd) stab_bad++;
      if (wcnt == waits) begin
        pready  = 1'b1;
        pslverr = err_en && (paddr == err_addr);
        if (pwrite) prdata = r;
        else if (paddr == STATUS_ADDR) begin
          prdata = {r[31:1], (status_reads - poll_base) < busy_cfg};
          status_reads++;
          last_status = prdata;
        end else prdata = rd_value;
        act_q.push_back(mk(paddr, pwrite, pwdata));
      end else begin
        pready  = 1'b0;
        pslverr = r[1];
        prdata  = r;
        wcnt++;
      end
    end else begin
      pready  = r[0];
      pslverr = r[1];
      prdata  = r;
      wcnt    = 0;
      if (psel) begin
        su_addr = paddr;
        su_wr   = pwrite;
        su_wd   = pwdata;
      end else if (penable || pwrite || paddr != 32'h0 || pwdata != 32'h0) stab_bad++;
    end
  end

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int w, input int busy, input bit eerr,
                        input logic [31:0] eaddr, input logic [31:0] rdv);
    xfer_t       exp_q[$];
    logic [31:0] exp_rdata, cap_rdata;
    bit          exp_err, exp_to, ctrl_err;
    logic        cap_err, cap_to;
    int          exp_e, e, base_x, stab_base, psel_base, npoll, hold;
    waits     = w;
    busy_cfg  = busy;
    err_en    = eerr;
    err_addr  = eaddr;
    rd_value  = rdv;
    poll_base = status_reads;
    base_x    = act_q.size();
    stab_base = stab_bad;
    psel_base = psel_cycles;
    exp_err   = 1'b0;
    exp_to    = 1'b0;
    exp_rdata = '0;
    ctrl_err  = 1'b0;
    case (op)
      2'd0: begin
        exp_q.push_back(mk(addr, 1'b0, 32'h0));
        exp_err   = eerr && (addr == eaddr);
        exp_rdata = rdv;
      end
      2'd1: begin
        exp_q.push_back(mk(addr, 1'b1, wd));
        exp_err = eerr && (addr == eaddr);
      end
      2'd2: begin
        exp_q.push_back(mk(CTRL_ADDR, 1'b1, wd | 32'h1));
        ctrl_err = eerr && (eaddr == CTRL_ADDR);
        exp_err  = ctrl_err;
        if (!ctrl_err) begin
          npoll  = (busy < POLL_MAX) ? busy + 1 : POLL_MAX;
          exp_to = (busy >= POLL_MAX);
          repeat (npoll) exp_q.push_back(mk(STATUS_ADDR, 1'b0, 32'h0));
        end
      end
      default: exp_err = 1'b1;
    endcase
    exp_e = (op == 2'd3) ? 0 : exp_q.size() * (2 + w);

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    chk({tag, "/cmd_ready"}, 128'(cmd_ready), 128'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    chk({tag, "/after_accept"}, 128'({cmd_ready, psel, penable}), 128'({1'b0, op != 2'd3, 1'b0}));
    e = 1;
    if (op != 2'd3) begin
      @(negedge clk);
      e++;
      chk({tag, "/access"}, 128'({psel, penable}), 128'(2'b11));
    end
    while (!rsp_valid && e < 600) begin
      @(negedge clk);
      e++;
    end
    chk({tag, "/latency"}, 128'(e - 1), 128'(exp_e));

    cap_rdata = rsp_rdata;
    cap_err   = rsp_err;
    cap_to    = rsp_timeout;
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "/hold"}, 128'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}),
          128'({1'b1, cap_rdata, cap_err, cap_to}));
    end
    if (op == 2'd2) begin
      if (!ctrl_err) begin
        chk({tag, "/rdata"}, 128'(cap_rdata), 128'(last_status));
        chk({tag, "/busy_bit"}, 128'(cap_rdata[0]), 128'(exp_to));
      end
    end else chk({tag, "/rdata"}, 128'(cap_rdata), 128'(exp_rdata));
    chk({tag, "/err"}, 128'(cap_err), 128'(exp_err));
    chk({tag, "/timeout"}, 128'(cap_to), 128'(exp_to));

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "/consumed"}, 128'({rsp_valid, cmd_ready}), 128'(2'b01));
    chk({tag, "/n_xfer"}, 128'(act_q.size() - base_x), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base_x + i < act_q.size())
        chk({tag, "/xfer"}, 128'(act_q[base_x + i]), 128'(exp_q[i]));
    chk({tag, "/bus_protocol"}, 128'(stab_bad - stab_base), 128'(0));
    if (op == 2'd3) chk({tag, "/no_psel"}, 128'(psel_cycles - psel_base), 128'(0));
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] addr, eaddr;
    bit          eerr;

    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs", 128'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                               psel, penable, pwrite, paddr, pwdata}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 128'(cmd_ready), 128'(0));
    @(negedge clk);
    chk("ready_after_edge", 128'(cmd_ready), 128'(1));

    do_cmd("read_10",     2'd0, 32'h10, 32'h0,  0, 0,    1'b0, 32'h0, 32'hDEADBEEF);
    do_cmd("write_04_w3", 2'd1, 32'h04, 32'h5,  3, 0,    1'b0, 32'h0, 32'h0);
    do_cmd("run_busy3",   2'd2, 32'h0,  32'h34, 0, 3,    1'b0, 32'h0, 32'h0);
    do_cmd("run_stuck",   2'd2, 32'h0,  32'h34, 0, 1000, 1'b0, 32'h0, 32'h0);
    do_cmd("write_0c_err",2'd1, 32'h0C, 32'h9,  0, 0,    1'b1, 32'h0C, 32'h0);
    do_cmd("run_ctrl_err",2'd2, 32'h0,  32'h10, 1, 2,    1'b1, CTRL_ADDR, 32'h0);
    do_cmd("reserved",    2'd3, 32'h40, 32'h1,  0, 0,    1'b0, 32'h0, 32'h0);

    // reset while ACCESS is stretched by wait states
    waits    = 6;
    busy_cfg = 0;
    err_en   = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_addr  = 32'h20;
    cmd_wdata = 32'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_reset/in_access", 128'({psel, penable}), 128'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset/outputs", 128'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                                   psel, penable, pwrite, paddr, pwdata}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_reset/ready_low", 128'(cmd_ready), 128'(0));
    @(negedge clk);
    chk("mid_reset/ready_high", 128'({cmd_ready, rsp_valid, psel}), 128'(3'b100));

    for (int n = 0; n < 40; n++) begin
      op   = 2'($urandom_range(0, 3));
      addr = $urandom & 32'hFFFF_FFFC;
      if (addr == STATUS_ADDR) addr = 32'h10;
      eerr  = ($urandom_range(0, 4) == 0);
      eaddr = (op == 2'd2) ? CTRL_ADDR : addr;
      do_cmd("random", op, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 6),
             eerr, eaddr, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_apb_master.md
# matmul_apb_master

APB initiator that drives the matrix-multiplier IP's APB register port from a simple command interface. It issues single reads and writes. It also provides a RUN macro: write CTRL with the start bit set, then poll STATUS until busy clears or a poll limit expires. It sits between the testbench or host-side sequencer and the matmul APB slave, and is the requesting end of the same bus the slave responds on.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- POLL_MAX, 1024, maximum STATUS reads per RUN before timeout (≥1)
- CTRL_ADDR, 'h00, CTRL register address (bit0 start, [3:2] read target, [5:4] write target)
- STATUS_ADDR, 'h0C, STATUS register address (bit0 busy)
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o
- cmd_op_i  in  2  00 READ, 01 WRITE, 10 RUN, 11 reserved
- cmd_addr_i  in  ADDR_W  target address (READ/WRITE; ignored for RUN)
- cmd_wdata_i  in  DATA_W  write data (WRITE), CTRL value (RUN)
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when rsp_valid_o & rsp_ready_i
- rsp_rdata_o  out  DATA_W  read data (READ), last STATUS value (RUN), 0 (WRITE)
- rsp_err_o  out  1  pslverr seen, or reserved op
- rsp_timeout_o  out  1  RUN poll limit reached
- psel_o, penable_o, pwrite_o  out  1 each  APB control
- paddr_o  out  ADDR_W  APB address
- pwdata_o  out  DATA_W  APB write data
- prdata_i  in  DATA_W  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- Registers: cmd_op, poll_cnt (clog2(POLL_MAX+1) bits), is_poll flag.
- IDLE: cmd_ready_o=1. On accept, latch op/addr/data.
  - READ/WRITE go to SETUP with the command's address.
  - RUN goes to SETUP as a write to CTRL_ADDR with pwdata = cmd_wdata_i | 1. Bit0 is forced to 1.
  - Reserved op goes straight to RESP with rsp_err_o=1 and no bus activity.
- SETUP: psel_o=1, penable_o=0. Always lasts one cycle, then ACCESS.
- ACCESS: psel_o=1, penable_o=1. Remain in ACCESS while pready_i=0. On pready_i=1, sample prdata_i and pslverr_i.
  - READ/WRITE go to RESP. rdata is prdata (READ) or 0 (WRITE); err is pslverr.
  - RUN CTRL write with pslverr=1 goes to RESP with err=1 and no polling.
  - RUN CTRL write with pslverr=0: set is_poll, clear poll_cnt, then SETUP as a read of STATUS_ADDR.
  - Poll read with pslverr=1: RESP with err=1.
  - Poll read with prdata[0]=0: RESP with rdata=status, err=0.
  - Poll read with busy=1: poll_cnt+1. If the new count equals POLL_MAX, go to RESP with timeout=1 and rdata=status. Otherwise go back to SETUP for another STATUS read.
- RESP: rsp_valid_o=1 with stable rdata/err/timeout. Return to IDLE when rsp_ready_i=1.
- paddr_o, pwrite_o and pwdata_o are stable from SETUP through the last ACCESS cycle, and are driven 0 whenever psel_o=0.
- pwdata_o is 0 for reads.
- Exactly one outstanding command at a time.

## Timing
- Reset values (asynchronous, rst_ni=0): state IDLE and every output 0, including cmd_ready_o. cmd_ready_o goes to 1 on the first rising edge after rst_ni rises.
- A reset mid-transfer drops psel_o and penable_o immediately and discards any pending response.
- Command accepted at edge N: psel_o=1 after N, penable_o=1 after N+1.
- With zero wait states, a READ/WRITE has rsp_valid_o=1 after edge N+2. Each cycle of pready_i=0 adds one cycle.
- Reserved op: rsp_valid_o=1 after N, with no bus activity.
- RUN, zero wait states, K polls: 2 cycles for the CTRL write plus 2 cycles per poll. There is no idle cycle between transfers: psel_o stays high and penable_o drops for the SETUP cycle.
- rsp_valid_o and rsp_ready_i high in the same cycle: response consumed and state returns to IDLE. The next command is accepted at the earliest one cycle later, since cmd_ready_o is 0 in RESP.
- cmd_valid_i while busy is ignored; the requester holds it.
- pready_i or pslverr_i outside ACCESS are ignored.

## Test plan
- READ 'h10, slave returns 'hDEADBEEF with 0 waits: SETUP then ACCESS. rsp_valid_o two cycles after accept with rdata 'hDEADBEEF, err 0.
- WRITE 'h04 data 'h5 with 3 wait states: ACCESS lasts 4 cycles, paddr and pwdata stable throughout. rsp rdata 0, err 0.
- RUN cmd_wdata 'h34: CTRL write pwdata 'h35. Slave reports busy for 3 polls, then 0: exactly 4 STATUS reads, rsp rdata bit0=0, err 0, timeout 0.
- RUN with POLL_MAX=4 and busy stuck at 1: exactly 4 polls, then rsp timeout=1, rdata bit0=1.
- WRITE 'h0C, slave asserts pslverr: rsp err=1. RUN whose CTRL write gets pslverr: err=1 and no STATUS read is issued.
- Reserved op 11: immediate rsp err=1, psel_o never asserted. Reset asserted during ACCESS: all outputs 0 at once, cmd_ready_o=1 one edge after release.
